// File: rtl/rft_inverse_engine.sv
// rft_inverse_engine: 8-point inverse resonance transform.
// Per-vertex polar-to-rect CORDIC, then an 8x8 real synthesis MAC.
// Ports: clk, reset (sync, active-high), start (sampled in IDLE),
//   vertex_amplitudes[0:7] (|X_k|), vertex_phases[0:7] (pi/32768 LSB),
//   raw_data_out (byte n at [8n+7:8n]), busy, output_valid (level).
module rft_inverse_engine (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic        [15:0] vertex_amplitudes [0:7],
  input  logic signed [15:0] vertex_phases [0:7],
  output logic        [63:0] raw_data_out,
  output logic               busy,
  output logic               output_valid
);

  typedef enum logic [1:0] {IDLE, POLAR, SYNTH} state_t;
  state_t state_q, state_d;

  logic        [15:0] amp_q [0:7];
  logic        [15:0] ph_q  [0:7];
  logic signed [17:0] re_q  [0:7];
  logic signed [17:0] im_q  [0:7];
  logic signed [18:0] x_q, y_q;
  logic signed [16:0] z_q;
  logic         [2:0] vtx_q, n_q, k_q;
  logic         [3:0] it_q;
  logic signed [37:0] acc_q;
  logic        [55:0] buf_q;

  function automatic logic signed [16:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 17'sd8192;
      4'd1:    atan_lut = 17'sd4836;
      4'd2:    atan_lut = 17'sd2555;
      4'd3:    atan_lut = 17'sd1297;
      4'd4:    atan_lut = 17'sd651;
      4'd5:    atan_lut = 17'sd326;
      4'd6:    atan_lut = 17'sd163;
      4'd7:    atan_lut = 17'sd81;
      4'd8:    atan_lut = 17'sd41;
      4'd9:    atan_lut = 17'sd20;
      4'd10:   atan_lut = 17'sd10;
      default: atan_lut = 17'sd5;
    endcase
  endfunction

  function automatic logic signed [15:0] cos_lut(input logic [2:0] m);
    case (m)
      3'd0:    cos_lut = 16'sd32767;
      3'd1:    cos_lut = 16'sd23170;
      3'd2:    cos_lut = 16'sd0;
      3'd3:    cos_lut = -16'sd23170;
      3'd4:    cos_lut = -16'sd32767;
      3'd5:    cos_lut = -16'sd23170;
      3'd6:    cos_lut = 16'sd0;
      default: cos_lut = 16'sd23170;
    endcase
  endfunction

  function automatic logic signed [15:0] sin_lut(input logic [2:0] m);
    case (m)
      3'd0:    sin_lut = 16'sd0;
      3'd1:    sin_lut = 16'sd23170;
      3'd2:    sin_lut = 16'sd32767;
      3'd3:    sin_lut = 16'sd23170;
      3'd4:    sin_lut = 16'sd0;
      3'd5:    sin_lut = -16'sd23170;
      3'd6:    sin_lut = -16'sd32767;
      default: sin_lut = -16'sd23170;
    endcase
  endfunction

  logic        [15:0] amp_s, ph_s, zp;
  logic               flip;
  logic signed [18:0] x_pre, x_sh, y_sh, x_nx, y_nx;
  logic signed [16:0] z_pre, z_nx;
  logic         [3:0] i_idx;
  logic signed [34:0] px, py;
  logic signed [17:0] re_d, im_d;
  logic         [2:0] m;
  logic signed [37:0] acc_nx, rnd;
  logic         [7:0] byte_d;
  logic        [63:0] word_d;

  // CORDIC: pre-rotation folds |phi| >= pi/2 into the
  // convergence range by negating x and adding pi.
  always_comb begin
    amp_s = amp_q[vtx_q];
    ph_s  = ph_q[vtx_q];
    flip  = ph_s[15] ^ ph_s[14];
    x_pre = flip ? -$signed({3'b000, amp_s})
                 :  $signed({3'b000, amp_s});
    zp    = flip ? (ph_s ^ 16'h8000) : ph_s;
    z_pre = {zp[15], zp};
    i_idx = it_q - 4'd1;
    x_sh  = x_q >>> i_idx;
    y_sh  = y_q >>> i_idx;
    if (z_q[16]) begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + atan_lut(i_idx);
    end else begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - atan_lut(i_idx);
    end
    px   = 35'(x_nx) * 35'sd19898;
    py   = 35'(y_nx) * 35'sd19898;
    re_d = 18'(px >>> 15);
    im_d = 18'(py >>> 15);
  end

  // Synthesis MAC; the final term is folded in before rounding.
  always_comb begin
    m      = k_q * n_q;
    acc_nx = acc_q
           + 38'(re_q[k_q]) * 38'(cos_lut(m))
           - 38'(im_q[k_q]) * 38'(sin_lut(m));
    rnd    = (acc_nx + 38'sd131072) >>> 18;
    if (rnd < 38'sd0)
      byte_d = 8'h00;
    else if (rnd > 38'sd255)
      byte_d = 8'hFF;
    else
      byte_d = rnd[7:0];
    word_d = {8'h00, buf_q};
    word_d[{n_q, 3'b000} +: 8] = byte_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = POLAR;
      POLAR:   if (vtx_q == 3'd7 && it_q == 4'd12) state_d = SYNTH;
      SYNTH:   if (n_q == 3'd7 && k_q == 3'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        amp_q[i] <= '0;
        ph_q[i]  <= '0;
        re_q[i]  <= '0;
        im_q[i]  <= '0;
      end
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      vtx_q        <= '0;
      it_q         <= '0;
      n_q          <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      buf_q        <= '0;
      raw_data_out <= '0;
      output_valid <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 8; i++) begin
              amp_q[i] <= vertex_amplitudes[i];
              ph_q[i]  <= vertex_phases[i];
            end
            output_valid <= 1'b0;
            vtx_q        <= '0;
            it_q         <= '0;
            n_q          <= '0;
            k_q          <= '0;
            acc_q        <= '0;
          end
        end
        POLAR: begin
          if (it_q == 4'd0) begin
            x_q  <= x_pre;
            y_q  <= '0;
            z_q  <= z_pre;
            it_q <= 4'd1;
          end else begin
            x_q <= x_nx;
            y_q <= y_nx;
            z_q <= z_nx;
            if (it_q == 4'd12) begin
              re_q[vtx_q] <= re_d;
              im_q[vtx_q] <= im_d;
              it_q        <= '0;
              vtx_q       <= vtx_q + 3'd1;
            end else begin
              it_q <= it_q + 4'd1;
            end
          end
        end
        SYNTH: begin
          k_q <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            acc_q <= '0;
            buf_q <= word_d[55:0];
            n_q   <= n_q + 3'd1;
            if (n_q == 3'd7) begin
              raw_data_out <= word_d;
              output_valid <= 1'b1;
            end
          end else begin
            acc_q <= acc_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rft_inverse_engine.sv
// tb_rft_inverse_engine: scoreboard bench for rft_inverse_engine.
// Driver queues expected words; monitor checks on output_valid rise.
module tb_rft_inverse_engine;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic        [15:0] amps [0:7];
  logic signed [15:0] phs  [0:7];
  logic        [63:0] raw_data_out;
  logic               busy;
  logic               output_valid;

  always #5 clk = ~clk;

  rft_inverse_engine dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .vertex_amplitudes (amps),
    .vertex_phases     (phs),
    .raw_data_out      (raw_data_out),
    .busy              (busy),
    .output_valid      (output_valid)
  );

  typedef struct {
    logic [63:0] val;
    int          tol;
    int          edge_n;
  } exp_t;

  exp_t        sb [$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] last_val = '0;
  int          last_tol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit close(logic [63:0] a, logic [63:0] e, int tol);
    for (int b = 0; b < 8; b++) begin
      int av = int'(a[8*b +: 8]);
      int ev = int'(e[8*b +: 8]);
      if (av - ev > tol || ev - av > tol) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chkw(string name, logic [63:0] act,
                      logic [63:0] exp, int tol);
    checks++;
    if (!close(act, exp, tol)) begin
      errors++;
      $display("FAIL %s: got %h want %h (+/-%0d per byte)",
               name, act, exp, tol);
    end
  endtask

  task automatic chki(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pk(int v0, int v1, int v2, int v3,
                                      int v4, int v5, int v6, int v7);
    return {16'(v7), 16'(v6), 16'(v5), 16'(v4),
            16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endfunction

  task automatic drive(logic [127:0] a, logic [127:0] p);
    for (int k = 0; k < 8; k++) begin
      amps[k] = a[16*k +: 16];
      phs[k]  = p[16*k +: 16];
    end
  endtask

  task automatic garbage();
    for (int k = 0; k < 8; k++) begin
      amps[k] = 16'h7777;
      phs[k]  = 16'sh4321;
    end
  endtask

  // Returns at the negedge just after the accepting edge E0.
  task automatic go(string name, logic [127:0] a, logic [127:0] p,
                    logic [63:0] exp, int tol);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    chki({name, "_idle"}, int'(busy), 0);
    drive(a, p);
    start = 1'b1;
    e.val    = exp;
    e.tol    = tol;
    e.edge_n = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    garbage();
    chki({name, "_busy"}, int'(busy), 1);
    chki({name, "_vclr"}, int'(output_valid), 0);
  endtask

  // Monitor: latency, data, and hold-until-next-start.
  initial begin
    exp_t e;
    logic pv = 1'b0;
    logic pb = 1'b0;
    forever begin
      @(negedge clk);
      if (output_valid && !pv) begin
        if (sb.size() == 0) begin
          chki("spurious_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chki("latency", cyc - e.edge_n, 168);
          chkw("result", raw_data_out, e.val, e.tol);
          chki("busy_done", int'(busy), 0);
          last_val = e.val;
          last_tol = e.tol;
        end
      end
      if (busy && !pb)
        chkw("hold", raw_data_out, last_val, last_tol);
      pv = output_valid;
      pb = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  localparam logic [127:0] Z = '0;

  initial begin
    int t;
    reset = 1'b1;
    start = 1'b0;
    garbage();
    repeat (3) @(negedge clk);
    chkw("rst_raw", raw_data_out, 64'h0, 0);
    chki("rst_busy", int'(busy), 0);
    chki("rst_valid", int'(output_valid), 0);
    reset = 1'b0;

    go("null", Z, Z, 64'h0, 0);
    go("dc", pk(64, 0, 0, 0, 0, 0, 0, 0), Z,
       64'h0808080808080808, 1);
    go("impulse", pk(255, 255, 255, 255, 255, 255, 255, 255), Z,
       64'h00000000000000FF, 1);
    go("nyquist", pk(1020, 0, 0, 0, 1020, 0, 0, 0), Z,
       64'h00FF00FF00FF00FF, 1);
    go("sat", pk(4000, 0, 0, 0, 0, 0, 0, 0), Z,
       64'hFFFFFFFFFFFFFFFF, 1);
    go("neg", pk(800, 0, 0, 0, 0, 0, 0, 0),
       pk(32768, 0, 0, 0, 0, 0, 0, 0), 64'h0, 1);

    // Start pulse at E50 with different inputs must be ignored.
    go("ctl", pk(64, 0, 0, 0, 0, 0, 0, 0), Z,
       64'h0808080808080808, 1);
    repeat (49) @(negedge clk);
    drive(pk(255, 255, 255, 255, 255, 255, 255, 255), Z);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    garbage();
    chki("ctl_e50_busy", int'(busy), 1);

    // Reset at E80 of a transform.
    go("rst", pk(255, 255, 255, 255, 255, 255, 255, 255), Z,
       64'h00000000000000FF, 1);
    repeat (79) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chkw("e80_raw", raw_data_out, 64'h0, 0);
    chki("e80_busy", int'(busy), 0);
    chki("e80_valid", int'(output_valid), 0);
    sb.delete();
    last_val = '0;
    last_tol = 0;
    reset = 1'b0;
    go("after_rst", pk(1020, 0, 0, 0, 1020, 0, 0, 0), Z,
       64'h00FF00FF00FF00FF, 1);

    // Forward-engine spectrum of 0x0123456789ABCDEF.
    go("roundtrip",
       pk(960, 355, 192, 147, 136, 147, 192, 355),
       pk(0, 'hD000, 'hE000, 'hF000, 0, 'h1000, 'h2000, 'h3000),
       64'h0123456789ABCDEF, 2);

    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chki("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
